// File: rtl/rst_ckpt.sv
// Register status table: per-register youngest ROB producer tag and valid bit,
// plus a circular queue of branch checkpoints for single-cycle mispredict recovery.
module rst_ckpt #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned NCKPT     = 4,
    parameter int unsigned ZERO_LOCK = 1,
    localparam int unsigned AW       = $clog2(NREG),
    localparam int unsigned CW       = $clog2(NCKPT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    Rsaddr_rst,
    output logic [TAG_W-1:0] Rstag_rst,
    output logic             Rsvalid_rst,
    input  logic [AW-1:0]    Rtaddr_rst,
    output logic [TAG_W-1:0] Rttag_rst,
    output logic             Rtvalid_rst,
    input  logic             Wen_rst,
    input  logic [AW-1:0]    Waddr_rst,
    input  logic [TAG_W-1:0] Wdata_rst,
    input  logic             RB_valid_rst,
    input  logic [TAG_W-1:0] RB_tag_rst,
    input  logic [AW-1:0]    RB_addr_rst,
    input  logic             Ckpt_save_rst,
    output logic [CW-1:0]    Ckpt_id_rst,
    output logic             Ckpt_full_rst,
    input  logic             Ckpt_free_rst,
    input  logic             Ckpt_restore_rst,
    input  logic [CW-1:0]    Ckpt_rid_rst,
    input  logic             Flush_rst,
    output logic [AW:0]      Busy_cnt_rst
);

    localparam int unsigned CNT_W = CW + 1;
    localparam int unsigned BSY_W = AW + 1;

    logic [NREG-1:0]  valid_q, valid_n;
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_n [NREG];
    logic [NREG-1:0]  ck_valid_q [NCKPT];
    logic [NREG-1:0]  ck_valid_n [NCKPT];
    logic [TAG_W-1:0] ck_tag_q [NCKPT][NREG];
    logic [TAG_W-1:0] ck_tag_n [NCKPT][NREG];
    logic [CW-1:0]    head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [BSY_W-1:0] busy_q, busy_n;

    logic full_c, do_save_c, do_free_c, clr_hit_c, ren_c;

    assign full_c    = (count_q == CNT_W'(NCKPT));
    assign do_save_c = Ckpt_save_rst && !full_c;
    assign do_free_c = Ckpt_free_rst && (count_q != '0);
    assign clr_hit_c = RB_valid_rst && (tag_q[RB_addr_rst] == RB_tag_rst);
    assign ren_c     = Wen_rst && !((ZERO_LOCK != 0) && (Waddr_rst == '0));

    // Next table / checkpoint state: flush, else restore, else clear+rename+save+free
    always_comb begin
        valid_n    = valid_q;
        tag_n      = tag_q;
        ck_valid_n = ck_valid_q;
        ck_tag_n   = ck_tag_q;
        head_n     = head_q;
        tail_n     = tail_q;
        count_n    = count_q;
        busy_n     = '0;

        // Commit clear reaches every slot; dead slots are overwritten before reuse
        for (int s = 0; s < int'(NCKPT); s++) begin
            if (RB_valid_rst && (ck_tag_q[s][RB_addr_rst] == RB_tag_rst)) begin
                ck_valid_n[s][RB_addr_rst] = 1'b0;
            end
        end

        if (Flush_rst) begin
            valid_n = '0;
            for (int i = 0; i < int'(NREG); i++) begin
                tag_n[i] = '0;
            end
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else if (Ckpt_restore_rst) begin
            valid_n = ck_valid_n[Ckpt_rid_rst];
            tag_n   = ck_tag_q[Ckpt_rid_rst];
            tail_n  = Ckpt_rid_rst;
            count_n = {1'b0, CW'(Ckpt_rid_rst - head_q)};
        end else begin
            if (clr_hit_c) begin
                valid_n[RB_addr_rst] = 1'b0;
            end
            if (ren_c) begin
                valid_n[Waddr_rst] = 1'b1;
                tag_n[Waddr_rst]   = Wdata_rst;
            end
            if (do_save_c) begin
                ck_valid_n[tail_q] = valid_n;
                ck_tag_n[tail_q]   = tag_n;
                tail_n             = tail_q + CW'(1);
            end
            if (do_free_c) begin
                head_n = head_q + CW'(1);
            end
            count_n = count_q + CNT_W'(do_save_c) - CNT_W'(do_free_c);
        end

        for (int i = 0; i < int'(NREG); i++) begin
            busy_n = busy_n + BSY_W'(valid_n[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                tag_q[i] <= '0;
            end
            for (int s = 0; s < int'(NCKPT); s++) begin
                ck_valid_q[s] <= '0;
                for (int i = 0; i < int'(NREG); i++) begin
                    ck_tag_q[s][i] <= '0;
                end
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            valid_q    <= valid_n;
            tag_q      <= tag_n;
            ck_valid_q <= ck_valid_n;
            ck_tag_q   <= ck_tag_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            busy_q     <= busy_n;
        end
    end

    // Lookups read registered state only; forwarding is the dispatcher's job
    assign Rstag_rst     = tag_q[Rsaddr_rst];
    assign Rsvalid_rst   = valid_q[Rsaddr_rst];
    assign Rttag_rst     = tag_q[Rtaddr_rst];
    assign Rtvalid_rst   = valid_q[Rtaddr_rst];
    assign Ckpt_id_rst   = tail_q;
    assign Ckpt_full_rst = full_c;
    assign Busy_cnt_rst  = busy_q;

endmodule

// File: tb/tb_rst_ckpt.sv
// Bench for rst_ckpt: directed scenarios then random traffic against a
// table-plus-checkpoint-list model.
module tb_rst_ckpt;

    logic       clock;
    logic       rst;
    logic [4:0] s_addr, t_addr, waddr, rb_addr;
    logic [4:0] s_tag, t_tag, wdata, rb_tag;
    logic       s_valid, t_valid, wen, rb_valid;
    logic       ck_save, ck_full, ck_free, ck_restore, flush;
    logic [1:0] ck_id, ck_rid;
    logic [5:0] busy;

    rst_ckpt dut (
        .clock(clock), .reset(rst),
        .Rsaddr_rst(s_addr), .Rstag_rst(s_tag), .Rsvalid_rst(s_valid),
        .Rtaddr_rst(t_addr), .Rttag_rst(t_tag), .Rtvalid_rst(t_valid),
        .Wen_rst(wen), .Waddr_rst(waddr), .Wdata_rst(wdata),
        .RB_valid_rst(rb_valid), .RB_tag_rst(rb_tag), .RB_addr_rst(rb_addr),
        .Ckpt_save_rst(ck_save), .Ckpt_id_rst(ck_id), .Ckpt_full_rst(ck_full),
        .Ckpt_free_rst(ck_free), .Ckpt_restore_rst(ck_restore), .Ckpt_rid_rst(ck_rid),
        .Flush_rst(flush), .Busy_cnt_rst(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: live checkpoints are a list ordered oldest-first, each tagged with its slot
    typedef struct packed {
        logic [1:0]       id;
        logic [31:0]      v;
        logic [31:0][4:0] t;
    } snap_t;

    logic [31:0]      mv;
    logic [31:0][4:0] mt;
    snap_t            q[$];
    int               nid;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = '0;
        mt = '0;
        q.delete();
        nid = 0;
    endtask

    task automatic model_step();
        snap_t e;
        int    k;
        bit    s_ok, f_ok;
        if (flush) begin
            model_reset();
        end else begin
            if (rb_valid) begin
                for (int j = 0; j < q.size(); j++) begin
                    e = q[j];
                    if (e.t[rb_addr] == rb_tag) e.v[rb_addr] = 1'b0;
                    q[j] = e;
                end
            end
            if (ck_restore) begin
                k = -1;
                for (int j = 0; j < q.size(); j++) if (q[j].id == ck_rid) k = j;
                if (k < 0) begin
                    chk("restore_rid_live", 32'(ck_rid), 32'hFFFF_FFFF);
                end else begin
                    mv = q[k].v;
                    mt = q[k].t;
                    while (q.size() > k) void'(q.pop_back());
                    nid = int'(ck_rid);
                end
            end else begin
                if (rb_valid && mt[rb_addr] == rb_tag) mv[rb_addr] = 1'b0;
                if (wen && waddr != 5'd0) begin
                    mv[waddr] = 1'b1;
                    mt[waddr] = wdata;
                end
                s_ok = ck_save && (q.size() < 4);
                f_ok = ck_free && (q.size() > 0);
                if (f_ok) void'(q.pop_front());
                if (s_ok) begin
                    e.id = 2'(nid);
                    e.v  = mv;
                    e.t  = mt;
                    q.push_back(e);
                    nid = (nid + 1) % 4;
                end
            end
        end
    endtask

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0;
        rb_valid = 0; rb_tag = 0; rb_addr = 0;
        ck_save = 0; ck_free = 0; ck_restore = 0; ck_rid = 0; flush = 0;
    endtask

    task automatic look(input int s, input int t);
        s_addr = 5'(s);
        t_addr = 5'(t);
        #1;
    endtask

    task automatic check_all();
        for (int i = 0; i < 32; i++) begin
            look(i, 31 - i);
            chk($sformatf("s_valid[%0d]", i), 32'(s_valid), 32'(mv[i]));
            if (mv[i]) chk($sformatf("s_tag[%0d]", i), 32'(s_tag), 32'(mt[i]));
            chk($sformatf("t_valid[%0d]", 31 - i), 32'(t_valid), 32'(mv[31 - i]));
            if (mv[31 - i]) chk($sformatf("t_tag[%0d]", 31 - i), 32'(t_tag), 32'(mt[31 - i]));
        end
        chk("ckpt_id", 32'(ck_id), 32'(nid));
        chk("ckpt_full", 32'(ck_full), 32'(q.size() == 4));
        chk("busy_cnt", 32'(busy), 32'($countones(mv)));
    endtask

    task automatic nx();
        @(negedge clock);
        idle();
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        idle();
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        s_addr = 0; t_addr = 0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_id", 32'(ck_id), 32'd0);
        chk("reset_full", 32'(ck_full), 32'd0);
        look(7, 9);
        chk("reset_s_valid", 32'(s_valid), 32'd0);
        chk("reset_s_tag", 32'(s_tag), 32'd0);
        chk("reset_t_valid", 32'(t_valid), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        check_all();

        // rename and zero-register lock
        nx(); wen = 1; waddr = 5; wdata = 7; tick();
        look(5, 0);
        chk("r5_tag7", 32'(s_tag), 32'd7);
        chk("r5_valid", 32'(s_valid), 32'd1);
        chk("busy_one", 32'(busy), 32'd1);
        nx(); wen = 1; waddr = 0; wdata = 3; tick();
        look(5, 0);
        chk("r0_locked", 32'(t_valid), 32'd0);

        // stale commit ignored, matching commit clears
        nx(); wen = 1; waddr = 5; wdata = 9; tick();
        nx(); rb_valid = 1; rb_tag = 7; rb_addr = 5; tick();
        look(5, 5);
        chk("r5_keep9_valid", 32'(s_valid), 32'd1);
        chk("r5_keep9_tag", 32'(s_tag), 32'd9);
        nx(); rb_valid = 1; rb_tag = 9; rb_addr = 5; tick();
        look(5, 5);
        chk("r5_cleared", 32'(s_valid), 32'd0);
        chk("busy_zero", 32'(busy), 32'd0);

        // rename beats same-cycle clear
        nx(); wen = 1; waddr = 8; wdata = 2; tick();
        nx(); wen = 1; waddr = 8; wdata = 4; rb_valid = 1; rb_tag = 2; rb_addr = 8; tick();
        look(8, 8);
        chk("r8_rename_wins_v", 32'(s_valid), 32'd1);
        chk("r8_rename_wins_t", 32'(s_tag), 32'd4);

        // checkpoint and restore
        nx(); wen = 1; waddr = 3; wdata = 1; tick();
        nx(); ck_save = 1; tick();
        nx(); wen = 1; waddr = 3; wdata = 6; tick();
        nx(); wen = 1; waddr = 4; wdata = 2; tick();
        nx(); ck_restore = 1; ck_rid = 0; tick();
        look(3, 4);
        chk("restore_r3_valid", 32'(s_valid), 32'd1);
        chk("restore_r3_tag", 32'(s_tag), 32'd1);
        chk("restore_r4_inval", 32'(t_valid), 32'd0);
        chk("restore_id", 32'(ck_id), 32'd0);
        chk("restore_full", 32'(ck_full), 32'd0);

        // fill, overflow, wrap, save+free
        for (int i = 0; i < 4; i++) begin
            nx(); ck_save = 1; tick();
        end
        chk("full_after4", 32'(ck_full), 32'd1);
        nx(); ck_save = 1; tick();
        chk("save_when_full_id", 32'(ck_id), 32'd0);
        nx(); ck_free = 1; tick();
        chk("free_not_full", 32'(ck_full), 32'd0);
        chk("free_id_wrap", 32'(ck_id), 32'd0);
        nx(); ck_save = 1; ck_free = 1; tick();
        chk("save_free_full", 32'(ck_full), 32'd0);
        chk("save_free_id", 32'(ck_id), 32'd1);

        // commit clear reaches a live checkpoint
        nx(); flush = 1; tick();
        nx(); wen = 1; waddr = 2; wdata = 5; tick();
        nx(); ck_save = 1; tick();
        nx(); rb_valid = 1; rb_tag = 5; rb_addr = 2; tick();
        nx(); ck_restore = 1; ck_rid = 0; tick();
        look(2, 2);
        chk("ckpt_clear_r2", 32'(s_valid), 32'd0);

        // flush beats rename
        nx(); wen = 1; waddr = 11; wdata = 3; tick();
        nx(); flush = 1; wen = 1; waddr = 9; wdata = 1; tick();
        look(9, 11);
        chk("flush_r9", 32'(s_valid), 32'd0);
        chk("flush_r11", 32'(t_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            nx();
            wen     = ($urandom_range(0, 9) < 6);
            waddr   = 5'($urandom);
            wdata   = 5'($urandom);
            rb_addr = 5'($urandom);
            rb_valid = ($urandom_range(0, 1) == 1);
            rb_tag  = ($urandom_range(0, 9) < 7) ? mt[rb_addr] : 5'($urandom);
            ck_save = ($urandom_range(0, 3) == 0);
            ck_free = ($urandom_range(0, 4) == 0);
            if (q.size() > 0 && $urandom_range(0, 11) == 0) begin
                ck_restore = 1;
                ck_rid = q[$urandom_range(0, q.size() - 1)].id;
            end
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end

        // asynchronous reset mid-operation
        nx(); wen = 1; waddr = 6; wdata = 12; tick();
        nx(); wen = 1; waddr = 7; wdata = 13; ck_save = 1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        look(6, 7);
        chk("areset_s_valid", 32'(s_valid), 32'd0);
        chk("areset_t_valid", 32'(t_valid), 32'd0);
        chk("areset_s_tag", 32'(s_tag), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_id", 32'(ck_id), 32'd0);
        chk("areset_full", 32'(ck_full), 32'd0);
        @(negedge clock);
        idle();
        rst = 1'b1;
        check_all();
        nx(); wen = 1; waddr = 6; wdata = 12; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rst_ckpt.md
Name: rst_ckpt

Overview:
- Parametrised register status table (RST) for the Tomasulo/ROB MIPS core; successor to the fixed 32x5-bit RST.
- Per architectural register, holds the ROB tag of the youngest in-flight producer plus a valid bit.
- Serves two dispatch source lookups, accepts dispatch renames and ROB commit clears.
- Adds a circular queue of branch checkpoints for single-cycle mispredict recovery, plus full flush and a busy count.

Parameters:
NREG, 32, number of architectural registers (power of 2)
TAG_W, 5, ROB tag width
NCKPT, 4, checkpoint slots (power of 2, >=2)
ZERO_LOCK, 1, 1 = register 0 never renamed
(AW = clog2(NREG), CW = clog2(NCKPT))

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
Rsaddr_rst  in  AW  source-s lookup address
Rstag_rst  out  TAG_W  tag for Rsaddr_rst
Rsvalid_rst  out  1  Rsaddr_rst has an in-flight producer
Rtaddr_rst  in  AW  source-t lookup address
Rttag_rst  out  TAG_W  tag for Rtaddr_rst
Rtvalid_rst  out  1  Rtaddr_rst has an in-flight producer
Wen_rst  in  1  dispatch rename enable
Waddr_rst  in  AW  destination register
Wdata_rst  in  TAG_W  ROB tag allocated to destination
RB_valid_rst  in  1  ROB commit broadcast
RB_tag_rst  in  TAG_W  committing tag
RB_addr_rst  in  AW  committing destination register
Ckpt_save_rst  in  1  take checkpoint (branch dispatch)
Ckpt_id_rst  out  CW  slot the next save will use
Ckpt_full_rst  out  1  all NCKPT slots in use
Ckpt_free_rst  in  1  oldest branch resolved correctly; release head slot
Ckpt_restore_rst  in  1  mispredict recovery
Ckpt_rid_rst  in  CW  slot to restore
Flush_rst  in  1  clear whole table and all checkpoints
Busy_cnt_rst  out  AW+1  number of valid table entries

Behaviour:
- Reset (reset=0, async): all valids=0, all tags=0, head=tail=0, count=0. Outputs: Rs/Rt valid=0, tags=0, Ckpt_id_rst=0, Ckpt_full_rst=0, Busy_cnt_rst=0.
- Lookups are combinational from registered state. There is no bypass of same-cycle write/clear; dispatch logic handles forwarding.
- Rename: Wen_rst sets entry[Waddr_rst] = {valid=1, tag=Wdata_rst} at the clock edge. With ZERO_LOCK=1, Waddr_rst=0 is ignored and entry 0 always reads valid=0.
- Commit clear: RB_valid_rst clears valid of entry[RB_addr_rst] only if the stored tag == RB_tag_rst; otherwise no change (a younger rename exists). The same tag-match clear is applied to that register in every live checkpoint.
- Same-cycle rename and clear on the same register: rename wins (entry = new tag, valid=1).
- Checkpoints are a circular queue with head (oldest), tail (next free) and count.
  - Save: snapshot = table state after this cycle's clear and rename; written to slot tail; tail++ mod NCKPT; count++.
  - Save while full is ignored, with no state change.
  - Ckpt_id_rst = tail; Ckpt_full_rst = (count==NCKPT).
- Free: head++, count--. Ignored when count==0. Branches resolve in order.
- Restore (Ckpt_rid_rst must be live):
  - table <= slot[rid] with this cycle's commit clear applied;
  - tail <= rid; count <= (rid - head) mod NCKPT, which frees rid and all younger slots;
  - same-cycle rename, save and free are ignored.
- Flush: all valids=0, head=tail=count=0. Same-cycle rename, clear, save, free and restore are ignored.
- Priority: reset > Flush > Restore > (rename, clear, save, free concurrently).
- Save and free in the same cycle: count unchanged, head and tail both advance. At count==0, free is ignored and save proceeds.
- Busy_cnt_rst is registered and equals the popcount of valids after each edge, with no lag.
- Wrap-around: tail and head wrap mod NCKPT. Full is determined by count, never by head==tail.
- Reset deasserted mid-operation: state starts from reset values; no input is sampled until the first rising edge with reset=1.

Test Plan:
- Reset then rename R5<-tag 7 -> next cycle Rsaddr=5 gives Rstag=7, Rsvalid=1, Busy_cnt=1. Rename R0<-3 -> Rtaddr=0 reads valid=0.
- R5<-7, then R5<-9, then commit (tag 7, R5) -> R5 stays valid tag 9. Commit (9, R5) -> R5 invalid, Busy_cnt=0.
- Same cycle: rename R8<-4 and commit (tag 2, R8) with R8 holding tag 2 -> R8 valid tag 4.
- R3<-1; save (id 0); R3<-6, R4<-2; restore rid=0 -> R3 tag 1 valid, R4 invalid, Ckpt_id=0, Ckpt_full=0.
- Save 4x -> Ckpt_full=1, fifth save ignored. Free -> full=0, Ckpt_id=0 (wrapped). Save+free in one cycle -> full stays 0, count unchanged.
- Checkpoint holds R2 tag 5; commit (5, R2); restore -> R2 invalid. Flush asserted with rename R9 -> all invalid, Busy_cnt=0. Mid-run reset=0 -> outputs 0 asynchronously.
